// File: rtl/exec_defs_pkg.sv
// Shared definitions for the execute stage: data width, opcode map and
// the multiplier FSM state encoding.
package exec_defs_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_AND = 7'h02;
  localparam logic [6:0] OP_OR  = 7'h03;
  localparam logic [6:0] OP_MUL = 7'h04;
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;
  localparam logic [6:0] OP_BEQ = 7'h30;
  localparam logic [6:0] OP_JMP = 7'h31;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_iterative.sv
// Iterative shift-and-add multiplier retiring MUL_STEP_BITS multiplier bits
// per cycle. Operands are latched on start, so upstream forwarding may change
// freely while busy. Optional macro MUL_EARLY_TERM_EN finishes as soon as the
// remaining multiplier bits are all zero.
module mul_iterative
  import exec_defs_pkg::*;
#(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int N     = XLEN / MUL_STEP_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_state_t         state, state_next;
  logic [CNT_W-1:0]   count;
  logic [31:0]        acc;
  logic [31:0]        mcand;
  logic [31:0]        mplier;
  logic [31:0]        mplier_shifted;

  // Sum of the multiplicand shifted by each set bit of the current digit.
  function automatic logic [31:0] partial(input logic [31:0] m,
                                          input logic [MUL_STEP_BITS-1:0] d);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < MUL_STEP_BITS; i++) begin
      if (d[i]) p = p + (m << i);
    end
    return p;
  endfunction

  assign mplier_shifted = mplier >> MUL_STEP_BITS;

  // Next-state logic: start from IDLE, iterate in BUSY, present result in DONE.
  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: begin
        if (start) begin
`ifdef MUL_EARLY_TERM_EN
          state_next = (op_b == '0) ? MUL_DONE : MUL_BUSY;
`else
          state_next = MUL_BUSY;
`endif
        end
      end
      MUL_BUSY: begin
        if (count == '0) state_next = MUL_DONE;
`ifdef MUL_EARLY_TERM_EN
        if (mplier_shifted == '0) state_next = MUL_DONE;
`endif
      end
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // State, counter and accumulator; reset abandons any product in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= MUL_IDLE;
      count <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= CNT_W'(N - 1);
          end
        end
        MUL_BUSY: begin
          acc    <= acc + partial(mcand, mplier[MUL_STEP_BITS-1:0]);
          mcand  <= mcand << MUL_STEP_BITS;
          mplier <= mplier_shifted;
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign idle    = (state == MUL_IDLE);
  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding from M and W, ALU and address
// generation, branch/jump resolution, and an iterative multiplier that holds
// the pipeline through x_stall. Optional macro MUL_EARLY_TERM_EN enables
// early termination inside the multiplier.
module execute_stage
  import exec_defs_pkg::*;
#(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_pc,
  input  logic [6:0]  x_opcode,
  input  logic [4:0]  x_src_reg_1,
  input  logic [4:0]  x_src_reg_2,
  input  logic [31:0] x_read_data_1,
  input  logic [31:0] x_read_data_2,
  input  logic [31:0] x_mem_offset,
  input  logic [31:0] x_brn_offset,
  input  logic [19:0] x_jmp_offset,
  input  logic        x_alu_imm_src,
  input  logic        m_reg_write,
  input  logic [4:0]  m_dst_reg,
  input  logic [31:0] m_alu_result,
  input  logic        w_reg_write,
  input  logic [4:0]  w_dst_reg,
  input  logic [31:0] w_write_data,
  output logic [31:0] x_alu_result,
  output logic [31:0] x_store_data,
  output logic        x_branch_taken,
  output logic [31:0] x_branch_target,
  output logic        x_stall
);

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mul_start;
  logic        mul_idle;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;

  // M has priority over W; register 0 always reads the register file value.
  function automatic logic [31:0] forward(input logic [4:0]  src,
                                          input logic [31:0] rf,
                                          input logic        m_we,
                                          input logic [4:0]  m_dst,
                                          input logic [31:0] m_val,
                                          input logic        w_we,
                                          input logic [4:0]  w_dst,
                                          input logic [31:0] w_val);
    if (m_we && (m_dst == src) && (src != '0)) return m_val;
    if (w_we && (w_dst == src) && (src != '0)) return w_val;
    return rf;
  endfunction

  assign op_a  = forward(x_src_reg_1, x_read_data_1, m_reg_write, m_dst_reg,
                         m_alu_result, w_reg_write, w_dst_reg, w_write_data);
  assign fwd_b = forward(x_src_reg_2, x_read_data_2, m_reg_write, m_dst_reg,
                         m_alu_result, w_reg_write, w_dst_reg, w_write_data);
  assign op_b  = x_alu_imm_src ? x_mem_offset : fwd_b;

  assign mul_start = (x_opcode == OP_MUL);

  mul_iterative #(
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .idle    (mul_idle),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result, branch decision and redirect target per opcode.
  always_comb begin
    alu_result    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    case (x_opcode)
      OP_ADD: alu_result = op_a + op_b;
      OP_SUB: alu_result = op_a - op_b;
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_MUL: alu_result = mul_done ? mul_product : '0;
      OP_LDB, OP_LDW, OP_STB, OP_STW: alu_result = op_a + op_b;
      OP_BEQ: begin
        branch_taken  = (op_a == fwd_b);
        branch_target = x_pc + x_brn_offset;
      end
      OP_JMP: begin
        branch_taken  = 1'b1;
        branch_target = x_pc + {{12{x_jmp_offset[19]}}, x_jmp_offset};
      end
      default: ;
    endcase
  end

  assign x_alu_result    = reset ? alu_result : '0;
  assign x_branch_taken  = reset & branch_taken;
  assign x_branch_target = reset ? branch_target : '0;
  assign x_store_data    = fwd_b;
  assign x_stall         = reset & ((mul_idle & mul_start) | mul_busy);

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the in-order pipeline. Sits directly downstream of the decode-to-execute pipeline register and consumes its x_* outputs.
- Resolves operand forwarding from the memory and writeback stages, computes ALU results and memory addresses, and resolves branches and jumps.
- Runs an iterative multiplier that holds the pipeline with x_stall until the product is ready.
- Outputs feed the execute-to-memory register. x_branch_taken drives d_flush upstream.

Parameters:
- MUL_STEP_BITS, 1, multiplier bits retired per iteration (legal: 1, 2, 4). N = 32/MUL_STEP_BITS iterations.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- x_pc  in  32  PC of the instruction in X.
- x_opcode  in  7  opcode.
- x_src_reg_1, x_src_reg_2  in  5 each  source register indices.
- x_read_data_1, x_read_data_2  in  32 each  register-file operands.
- x_mem_offset  in  32  M-type offset.
- x_brn_offset  in  32  B-type offset.
- x_jmp_offset  in  20  jump offset.
- x_alu_imm_src  in  1  operand B = x_mem_offset.
- m_reg_write, m_dst_reg[4:0], m_alu_result[31:0]  in  memory-stage forwarding source.
- w_reg_write, w_dst_reg[4:0], w_write_data[31:0]  in  writeback forwarding source.
- x_alu_result  out  32  ALU result, product, or memory address.
- x_store_data  out  32  forwarded operand B register value (for stores).
- x_branch_taken  out  1  redirect fetch; drives d_flush.
- x_branch_target  out  32  redirect PC.
- x_stall  out  1  hold decode-to-execute register; downstream inserts a bubble.

Behaviour:
- Forwarding, per operand: if m_reg_write and m_dst_reg==src and src!=0, use M; else if w_reg_write and w_dst_reg==src and src!=0, use W; else use read_data. M has priority. Register 0 is never forwarded.
- op_b = x_alu_imm_src ? x_mem_offset : forwarded operand 2.
- ADD: a+b. SUB: a-b. AND/OR: bitwise. All wrap mod 2^32.
- LDB/LDW/STB/STW: address = a+b.
- BEQ: x_alu_result = 0. Taken iff a==forwarded operand 2. Target = x_pc + x_brn_offset.
- JMP: always taken. Target = x_pc + sign_extend(x_jmp_offset).
- Undefined opcodes give result 0 and not-taken.
- Opcode 0 (ADD) is the pipeline bubble; it is harmless because its reg_write is 0.
- Non-MUL results are combinational, with zero added latency.
- MUL uses an FSM with states IDLE, BUSY, DONE.
  - IDLE: if x_opcode==MUL, latch forwarded a and b, clear the accumulator, set count=N-1, go to BUSY.
  - BUSY: each cycle add a·(b[MUL_STEP_BITS-1:0]) shifted into the accumulator, shift b. At count==0 go to DONE; otherwise decrement count.
  - DONE: x_alu_result = low 32 bits of the product; return to IDLE next cycle.
- x_stall = (IDLE && opcode==MUL) || BUSY. A MUL therefore stalls N+1 cycles and spends N+2 cycles in X.
- Forwarding inputs are ignored while in BUSY because operands were latched at entry.
- Back-to-back MULs: the second MUL is seen in IDLE the cycle after DONE and starts normally.
- Reset low: state goes to IDLE, count and accumulator go to 0. While reset is low, x_stall=0, x_branch_taken=0, x_branch_target=0, x_alu_result=0. Reset mid-MUL abandons the product.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In IDLE, if latched b==0, go straight to DONE (1 stall cycle).
  - In BUSY, go to DONE as soon as the shifted remaining b==0, even if count>0.
- Undefined: fixed N iterations; timing is data-independent.

Decomposition:
- Shared package/include exec_defs holds:
  - opcode localparams: OP_ADD=7'h00, OP_SUB=7'h01, OP_AND=7'h02, OP_OR=7'h03, OP_MUL=7'h04, OP_LDB=7'h10, OP_LDW=7'h11, OP_STB=7'h12, OP_STW=7'h13, OP_BEQ=7'h30, OP_JMP=7'h31;
  - MUL state encodings;
  - XLEN=32.
- Sub-module mul_iterative contains the FSM, counter and accumulator, with a start/busy/done interface.

Test Plan:
- ADD, a=0xFFFFFFFF, b=2, no forwarding -> x_alu_result=0x00000001 the same cycle, x_stall=0.
- Forwarding: src_reg_1=5 with m_dst_reg=5 (0x10) and w_dst_reg=5 (0x20), both reg_write=1 -> M wins, a=0x10. With src_reg_1=0 -> read_data used.
- MUL 7×6, MUL_STEP_BITS=1, macro off -> x_stall high exactly 33 cycles, then x_alu_result=42 with x_stall=0. Changing m_alu_result during BUSY does not affect the result.
- BEQ, a=b=9, x_pc=0x100, x_brn_offset=0x20 -> taken=1, target=0x120. JMP with x_jmp_offset=0xFFFFC -> target=x_pc-4.
- Reset low at the 10th BUSY cycle of a MUL -> next cycle state=IDLE; x_stall=0 while reset is low; a fresh MUL 3×3 then yields 9.
- MUL_EARLY_TERM_EN defined, MUL 3×5 -> x_stall high 4 cycles, result 15. MUL x×0 -> x_stall high 1 cycle, result 0.
